// File: rtl/reset_sequencer.sv
// Reset sequencer: async-assert / sync-deassert board reset, stretched and released per domain.
// Optional watchdog reset enabled by defining RSTSEQ_WDOG_EN.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 8,
  parameter int N_OUT          = 3,
  parameter int STEP_CYCLES    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_rst_req,
  input  logic             wdog_kick,
  output logic [N_OUT-1:0] rst_out_n,
  output logic             done,
  output logic             busy,
  output logic             wdog_fired
);

  localparam int MAX_SS = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
`ifdef RSTSEQ_WDOG_EN
  localparam int WDOG_CYCLES = 64;
  localparam int MAX_CNT     = (MAX_SS > WDOG_CYCLES) ? MAX_SS : WDOG_CYCLES;
`else
  localparam int MAX_CNT     = MAX_SS;
`endif
  localparam int CNT_W = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_CYCLES - 1);
  localparam logic [N_OUT-1:0] REL_ONE      = N_OUT'(1);

  typedef enum logic [1:0] {SYNC, STRETCH, RELEASE, RUN} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rst_sync;
  logic [N_OUT-1:0]       rel_next;
  logic                   wdog_trip;
  logic                   restart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync = sync[SYNC_STAGES-1];

  // Release order is a thermometer fill from bit 0; the sequence ends when it becomes all ones.
  assign rel_next = (rst_out_n << 1) | REL_ONE;
  assign restart  = (sw_rst_req && (state != SYNC)) || wdog_trip;

`ifdef RSTSEQ_WDOG_EN
  logic [CNT_W-1:0] wcnt;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

  assign wdog_trip = (state == RUN) && !wdog_kick && (wcnt == WDOG_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt       <= '0;
      wdog_fired <= 1'b0;
    end else begin
      if ((state != RUN) || wdog_kick || wdog_trip) wcnt <= '0;
      else                                          wcnt <= wcnt + CNT_ONE;
      if (wdog_trip) wdog_fired <= 1'b1;
    end
  end
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = wdog_kick;
  assign wdog_trip        = 1'b0;
  assign wdog_fired       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SYNC;
      cnt       <= '0;
      rst_out_n <= '0;
      done      <= 1'b0;
      busy      <= 1'b1;
    end else if (restart) begin
      // A request beats any release scheduled on the same edge.
      state     <= STRETCH;
      cnt       <= '0;
      rst_out_n <= '0;
      done      <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        SYNC: begin
          if (rst_sync) begin
            state <= STRETCH;
            cnt   <= '0;
          end
        end
        STRETCH, RELEASE: begin
          if (cnt == ((state == STRETCH) ? STRETCH_LAST : STEP_LAST)) begin
            rst_out_n <= rel_next;
            cnt       <= '0;
            if (&rel_next) begin
              state <= RUN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: cnt <= '0;
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters (watchdog checks follow RSTSEQ_WDOG_EN).
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       sw_rst_req;
  logic       wdog_kick;
  logic [2:0] rst_out_n;
  logic       done;
  logic       busy;
  logic       wdog_fired;

  int vecs;
  int errs;

  reset_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .wdog_kick (wdog_kick),
    .rst_out_n (rst_out_n),
    .done      (done),
    .busy      (busy),
    .wdog_fired(wdog_fired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {rst_out_n, done, busy} k edges into a sequence whose bit 0 releases at edge base.
  function automatic logic [4:0] exp_vec(input int k, input int base);
    logic [2:0] b;
    for (int i = 0; i < 3; i++) b[i] = (k >= base + 4 * i);
    return {b, &b, ~&b};
  endfunction

  task automatic test_reset;
    rst = 1'b1; sw_rst_req = 1'b0; wdog_kick = 1'b0;
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({rst_out_n, done, busy, wdog_fired} !== 6'b000010) begin
      errs++;
      $display("FAIL reset_async: got %b expected 000010", {rst_out_n, done, busy, wdog_fired});
    end
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({rst_out_n, done, busy, wdog_fired} !== 6'b000010) begin
      errs++;
      $display("FAIL reset_held: got %b expected 000010", {rst_out_n, done, busy, wdog_fired});
    end
  endtask

  task automatic test_poweron;
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      vecs++;
      if ({rst_out_n, done, busy} !== exp_vec(e, 11)) begin
        errs++;
        $display("FAIL poweron edge %0d: got %b expected %b", e, {rst_out_n, done, busy}, exp_vec(e, 11));
      end
    end
  endtask

  task automatic test_abort;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      vecs++;
      if ({rst_out_n, done, busy} !== exp_vec(e, 11)) begin
        errs++;
        $display("FAIL abort_pre edge %0d: got %b expected %b", e, {rst_out_n, done, busy}, exp_vec(e, 11));
      end
    end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({rst_out_n, done, busy} !== 5'b00001) begin
      errs++;
      $display("FAIL abort_async: got %b expected 00001", {rst_out_n, done, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      vecs++;
      if ({rst_out_n, done, busy} !== exp_vec(e, 11)) begin
        errs++;
        $display("FAIL abort_replay edge %0d: got %b expected %b", e, {rst_out_n, done, busy}, exp_vec(e, 11));
      end
    end
  endtask

  task automatic test_sw_run;
    @(negedge clk); sw_rst_req = 1'b1;
    @(posedge clk); #1; sw_rst_req = 1'b0;
    vecs++;
    if ({rst_out_n, done, busy} !== 5'b00001) begin
      errs++;
      $display("FAIL sw_run_assert: got %b expected 00001", {rst_out_n, done, busy});
    end
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      vecs++;
      if ({rst_out_n, done, busy} !== exp_vec(k, 8)) begin
        errs++;
        $display("FAIL sw_run rel %0d: got %b expected %b", k, {rst_out_n, done, busy}, exp_vec(k, 8));
      end
    end
  endtask

  task automatic test_sw_collide;
    @(negedge clk); sw_rst_req = 1'b1;
    @(posedge clk); #1; sw_rst_req = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      vecs++;
      if ({rst_out_n, done, busy} !== exp_vec(k, 8)) begin
        errs++;
        $display("FAIL collide_pre rel %0d: got %b expected %b", k, {rst_out_n, done, busy}, exp_vec(k, 8));
      end
    end
    @(negedge clk); sw_rst_req = 1'b1;
    @(posedge clk); #1; sw_rst_req = 1'b0;
    vecs++;
    if ({rst_out_n, done, busy} !== 5'b00001) begin
      errs++;
      $display("FAIL collide_edge: got %b expected 00001", {rst_out_n, done, busy});
    end
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      vecs++;
      if ({rst_out_n, done, busy} !== exp_vec(k, 8)) begin
        errs++;
        $display("FAIL collide_post rel %0d: got %b expected %b", k, {rst_out_n, done, busy}, exp_vec(k, 8));
      end
    end
  endtask

  task automatic test_sync_hold;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    sw_rst_req = 1'b1;
    rst = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      if (e == 3) sw_rst_req = 1'b0;
      vecs++;
      if ({rst_out_n, done, busy} !== exp_vec(e, 11)) begin
        errs++;
        $display("FAIL sync_hold edge %0d: got %b expected %b", e, {rst_out_n, done, busy}, exp_vec(e, 11));
      end
    end
  endtask

  task automatic test_wdog;
    logic [5:0] exp6;
    @(negedge clk); sw_rst_req = 1'b1;
    @(posedge clk); #1; sw_rst_req = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
`ifdef RSTSEQ_WDOG_EN
      if (k < 80)       exp6 = {exp_vec(k, 8), 1'b0};
      else if (k == 80) exp6 = 6'b000011;
      else              exp6 = {exp_vec(k - 80, 8), 1'b1};
`else
      exp6 = {exp_vec(k, 8), 1'b0};
`endif
      vecs++;
      if ({rst_out_n, done, busy, wdog_fired} !== exp6) begin
        errs++;
        $display("FAIL wdog_idle rel %0d: got %b expected %b", k, {rst_out_n, done, busy, wdog_fired}, exp6);
      end
    end
  endtask

  task automatic test_wdog_kick;
    logic dropped;
    logic fired0;
    dropped = 1'b0;
    fired0  = wdog_fired;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); wdog_kick = (i % 60 == 0);
      @(posedge clk); #1;
      if ({rst_out_n, done, busy} !== 5'b11110) dropped = 1'b1;
    end
    wdog_kick = 1'b0;
    vecs++;
    if (dropped !== 1'b0 || wdog_fired !== fired0) begin
      errs++;
      $display("FAIL wdog_kick: dropped=%b fired=%b expected dropped=0 fired=%b", dropped, wdog_fired, fired0);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset;
    test_poweron;
    test_abort;
    test_sw_run;
    test_sw_collide;
    test_sync_hold;
    test_wdog;
    test_wdog_kick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Upstream reset source for the flop-based datapath. It feeds the active-low `rst` inputs of the `dff_sync_rst` / `dff_async_rst` style registers.
- Takes a raw board reset and produces N_OUT active-low domain resets:
  - assertion is asynchronous;
  - deassertion is synchronised, stretched, then released one domain at a time with a fixed gap.
- Also supports a synchronous software-requested reset cycle.

Parameters:
- SYNC_STAGES, 2: deassertion synchroniser depth; legal range >= 2.
- STRETCH_CYCLES, 8: cycles all outputs stay asserted after the synchroniser output goes high; legal range >= 1.
- N_OUT, 3: number of sequenced reset outputs; legal range >= 1.
- STEP_CYCLES, 4: cycles between consecutive domain releases; legal range >= 1.
- Internal counter width is a localparam: $clog2 of max(STRETCH_CYCLES, STEP_CYCLES, WDOG_CYCLES) + 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low raw reset.
- sw_rst_req, input, 1: synchronous one-cycle software reset request.
- wdog_kick, input, 1: watchdog service pulse; used only with the optional feature.
- rst_out_n, output, N_OUT: active-low domain resets; bit 0 is released first.
- done, output, 1: high when every rst_out_n bit is released.
- busy, output, 1: high while a sequence is in progress (states SYNC, STRETCH, RELEASE).
- wdog_fired, output, 1: sticky flag, set when a watchdog reset has occurred.

Behaviour:
- rst low, asynchronous and immediate with no clock needed:
  - rst_out_n = 0, done = 0, busy = 1, wdog_fired = 0;
  - synchroniser cleared; counters cleared; state = SYNC.
- Synchroniser: SYNC_STAGES flops with D tied to 1, asynchronously cleared by rst. Its output is rst_sync.
- Timing origin: edge 1 is the first posedge of clk after rst rises. Setup to that edge is required.
  - rst_sync goes high after edge SYNC_STAGES.
- State SYNC: on the first edge that samples rst_sync = 1, go to STRETCH with the counter at 0.
- State STRETCH:
  - the counter increments each edge;
  - on the edge where it reaches STRETCH_CYCLES, go to RELEASE and raise rst_out_n[0] on that same edge.
- State RELEASE:
  - rst_out_n[i] rises on edge E0 + i*STEP_CYCLES, where E0 = SYNC_STAGES + 1 + STRETCH_CYCLES;
  - at defaults, E0 = 11 and bits rise at edges 11, 15 and 19;
  - a released bit stays high until the next reset event.
- State RUN:
  - entered on the edge that releases bit N_OUT-1;
  - done = 1 and busy = 0 on that same edge.
- All rst_out_n rising edges are registered, glitch-free and clk-aligned. Only falling edges may be asynchronous, and only via rst.
- sw_rst_req:
  - in RUN: on the next edge, all rst_out_n = 0, done = 0, busy = 1, state = STRETCH with the counter at 0. Release then follows STRETCH_CYCLES later, then STEP_CYCLES per bit.
  - in STRETCH or RELEASE: same as RUN. Outputs are re-asserted and the stretch restarts.
  - in SYNC: ignored.
  - a request on the same edge as a scheduled release wins; the bit stays low.
- rst low in any state aborts the sequence asynchronously, as in the first rule.
- N_OUT = 1: RUN is entered at E0.

Optional Feature:
- Macro: RSTSEQ_WDOG_EN, adding a localparam WDOG_CYCLES = 64.
- Defined:
  - in RUN, a counter increments each cycle and clears on wdog_kick = 1;
  - on the edge it reaches WDOG_CYCLES, the block behaves exactly as sw_rst_req in RUN, and wdog_fired is set;
  - wdog_fired clears only on rst;
  - the counter is held at 0 outside RUN.
- Undefined:
  - wdog_kick is ignored;
  - wdog_fired is constant 0;
  - no watchdog logic is generated.

Test Plan:
- Power-on at defaults (rst low for 3 cycles, then high) -> rst_out_n = 000 during reset; bit 0 rises at edge 11, bit 1 at edge 15, bit 2 at edge 19. done and busy change at edge 19.
- Mid-sequence abort: rst goes low between edges 13 and 14 -> rst_out_n = 000 immediately, with no clk edge needed. A new deassertion replays the full power-on timing.
- sw_rst_req pulse in RUN at edge T -> rst_out_n = 000 and done = 0 after edge T+1. Bits then rise at T+1+8, T+1+12 and T+1+16.
- sw_rst_req on the same edge as the bit-1 release -> bit 1 stays 0. Outputs drop to 000 and the stretch restarts.
- sw_rst_req held high during SYNC -> no effect; release timing is identical to the first scenario.
- RSTSEQ_WDOG_EN defined, with no kick for 64 cycles in RUN -> rst_out_n = 000 and wdog_fired = 1, with wdog_fired still 1 after re-release. Kicking every 60 cycles -> no reset. Macro undefined -> wdog_fired is always 0.
